// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage PC unit: next-PC select codes and RUN/HALT state.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_RETURN = 2'b11
  } next_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ras_unit_if.sv
// Control/status bundle between the fetch controller (master) and pc_ras_unit (slave).
interface pc_ras_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Stall;
  logic [1:0]       NextSel;
  logic [WIDTH-1:0] Address;
  logic [WIDTH-1:0] Offset;
  logic             Push;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlus;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasOverflow;
  logic             ReturnMiss;
  logic             Fault;

  modport master (
    output Stall, NextSel, Address, Offset, Push,
    input  PCResult, PCPlus, RasEmpty, RasFull, RasOverflow, ReturnMiss, Fault
  );

  modport slave (
    input  Stall, NextSel, Address, Offset, Push,
    output PCResult, PCPlus, RasEmpty, RasFull, RasOverflow, ReturnMiss, Fault
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address LIFO; a push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_replace;

  assign w_top_idx  = r_ptr - PTR_W'(1);
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(RAS_DEPTH));
  assign o_overflow = r_overflow;
  assign o_top      = r_mem[w_top_idx];

  // Push+pop on a non-empty stack swaps the top in place; on an empty stack it is a plain push.
  assign w_replace = i_push && i_pop && !o_empty;
  assign w_wr_idx  = w_replace ? w_top_idx : r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_push && !w_replace) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (o_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop && !i_push && !o_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage PC with internal next-PC mux and return-address stack.
// Define PC_ALIGN_CHECK_EN to trap misaligned targets into a sticky HALT/Fault state.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic         Clk,
  input logic         Reset,
  pc_ras_unit_if.slave bus
);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pc_plus;
  logic             r_return_miss;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_top;
  logic             w_run;
  logic             w_load;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_overflow;
  next_sel_e        w_sel;

  assign w_sel    = next_sel_e'(bus.NextSel);
  assign w_pc_inc = r_pc + INC_W;

  // Next-PC mux; a return on an empty stack falls through to the sequential PC.
  always_comb begin
    w_next_pc = w_pc_inc;
    case (w_sel)
      SEL_BRANCH: w_next_pc = w_pc_inc + bus.Offset;
      SEL_JUMP:   w_next_pc = bus.Address;
      SEL_RETURN: if (!w_empty) w_next_pc = w_top;
      default:    w_next_pc = w_pc_inc;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  pc_state_e r_state;
  pc_state_e w_state_nxt;
  logic      w_misalign;

  assign w_misalign = ((w_next_pc & WIDTH'(INC - 1)) != '0);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HALT is left only through reset; the stack still updates on the trapping cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_run = !bus.Stall;
        if (w_run && w_misalign) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_load = w_run;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  assign bus.Fault = (r_state == ST_HALT);
`else
  assign w_run     = !bus.Stall;
  assign w_load    = w_run;
  assign bus.Fault = 1'b0;
`endif

  assign w_push = w_run && bus.Push;
  assign w_pop  = w_run && (w_sel == SEL_RETURN);

  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_data(w_pc_inc),
    .o_top      (w_top),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_overflow (w_overflow)
  );

  // PC+INC is registered alongside the PC so the link path starts from a flop.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_pc          <= RESET_VECTOR;
      r_pc_plus     <= RESET_VECTOR + INC_W;
      r_return_miss <= 1'b0;
    end else begin
      r_return_miss <= w_pop && w_empty;
      if (w_load) begin
        r_pc      <= w_next_pc;
        r_pc_plus <= w_next_pc + INC_W;
      end
    end
  end

  assign bus.PCResult    = r_pc;
  assign bus.PCPlus      = r_pc_plus;
  assign bus.RasEmpty    = w_empty;
  assign bus.RasFull     = w_full;
  assign bus.RasOverflow = w_overflow;
  assign bus.ReturnMiss  = r_return_miss;

endmodule
